wb_ram_bist_master: RTL and testbench

// - Wishbone initiator that exercises the FPGA RAM responders from inside the fabric.
// - Phase 1 (WRITE) writes a computed pattern to words 0..len_i-1.
// - Phase 2 (READ) reads the same words back, compares them with the pattern and reports pass/fail.
// - Drives a CYC/STB/WE/BYTE_STB/ADR/DAT bus into one RAM window. Intended for bring-up and self-test.

---
 rtl/wb_ram_bist_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_wb_ram_bist_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_bist_master.sv
// Wishbone write-then-readback BIST initiator for the fabric RAM windows.
// Optional per-access ACK timeout is enabled by defining WB_BIST_TIMEOUT_EN.
module wb_ram_bist_master #(
    parameter int unsigned ADDRWIDTH = 11,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned CMP_WIDTH = 16
`ifdef WB_BIST_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 start_i,
    input  logic [ADDRWIDTH:0]   len_i,
    input  logic [DATAWIDTH-1:0] seed_i,
    input  logic                 invert_i,
    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    input  logic [DATAWIDTH-1:0] WBm_DAT_i,
    input  logic                 WBm_ACK_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [15:0]          err_cnt_o,
    output logic [ADDRWIDTH-1:0] first_err_adr_o
);

    localparam int unsigned LENW = ADDRWIDTH + 1;
    localparam logic [DATAWIDTH-1:0] CMP_MASK = DATAWIDTH'((64'd1 << CMP_WIDTH) - 64'd1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_STB = 3'd1;
    localparam logic [2:0] S_WR_GAP = 3'd2;
    localparam logic [2:0] S_RD_STB = 3'd3;
    localparam logic [2:0] S_RD_GAP = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    // Test word for an address: low CMP_WIDTH bits of adr^seed, optionally inverted.
    function automatic logic [DATAWIDTH-1:0] pat(input logic [ADDRWIDTH-1:0] a,
                                                 input logic [DATAWIDTH-1:0] seed,
                                                 input logic inv);
        logic [DATAWIDTH-1:0] p;
        p = (DATAWIDTH'(a) ^ seed) & CMP_MASK;
        if (inv) p = p ^ CMP_MASK;
        return p;
    endfunction

    logic [2:0]           state_q, state_d;
    logic [ADDRWIDTH-1:0] adr_q, adr_d;
    logic [LENW-1:0]      len_q, len_d;
    logic [DATAWIDTH-1:0] seed_q, seed_d;
    logic                 inv_q, inv_d;
    logic                 cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic [DATAWIDTH-1:0] dat_q, dat_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [15:0]          err_q, err_d;
    logic [ADDRWIDTH-1:0] first_q, first_d;
    logic                 tmo_q, tmo_d;
`ifdef WB_BIST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
`endif

    logic                 last_c;
    logic [ADDRWIDTH-1:0] nxt_adr_c;
    logic [DATAWIDTH-1:0] rd_pat_c;
    logic [DATAWIDTH-1:0] wr_pat_c;
    logic                 unused_dat_hi_c;

    assign last_c          = ({1'b0, adr_q} == len_q - LENW'(1));
    assign nxt_adr_c       = adr_q + ADDRWIDTH'(1);
    assign rd_pat_c        = pat(adr_q, seed_q, inv_q);
    assign wr_pat_c        = pat(nxt_adr_c, seed_q, inv_q);
    assign unused_dat_hi_c = ^(WBm_DAT_i & ~CMP_MASK);

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        len_d   = len_q;
        seed_d  = seed_q;
        inv_d   = inv_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        dat_d   = dat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        first_d = first_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                // done_q marks the cycle right after FIN; a start there is dropped.
                if (start_i && !done_q) begin
                    len_d   = len_i;
                    seed_d  = seed_i;
                    inv_d   = invert_i;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b0;
                    busy_d  = 1'b1;
                    adr_d   = '0;
                    if (len_i == '0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_WR_STB;
                        cyc_d   = 1'b1;
                        we_d    = 1'b1;
                        dat_d   = pat('0, seed_i, invert_i);
                    end
                end
            end
            S_WR_STB: begin
                if (WBm_ACK_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    dat_d   = '0;
                    state_d = S_WR_GAP;
                end
            end
            S_WR_GAP: begin
                cyc_d = 1'b1;
                if (last_c) begin
                    adr_d   = '0;
                    we_d    = 1'b0;
                    state_d = S_RD_STB;
                end else begin
                    adr_d   = nxt_adr_c;
                    we_d    = 1'b1;
                    dat_d   = wr_pat_c;
                    state_d = S_WR_STB;
                end
            end
            S_RD_STB: begin
                if (WBm_ACK_i) begin
                    cyc_d   = 1'b0;
                    state_d = S_RD_GAP;
                    if ((WBm_DAT_i & CMP_MASK) != rd_pat_c) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (err_q == 16'd0) first_d = adr_q;
                    end
                end
            end
            S_RD_GAP: begin
                if (last_c) begin
                    state_d = S_FIN;
                end else begin
                    adr_d   = nxt_adr_c;
                    cyc_d   = 1'b1;
                    state_d = S_RD_STB;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_q == 16'd0) && !tmo_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef WB_BIST_TIMEOUT_EN
        // Abandon a hung access and report it as the failing address.
        tmo_cnt_d = '0;
        if ((state_q == S_WR_STB || state_q == S_RD_STB) && !WBm_ACK_i) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
            if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_cnt_d = '0;
                cyc_d     = 1'b0;
                we_d      = 1'b0;
                dat_d     = '0;
                tmo_d     = 1'b1;
                first_d   = adr_q;
                state_d   = S_FIN;
            end
        end
`endif
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            len_q     <= '0;
            seed_q    <= '0;
            inv_q     <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            dat_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            first_q   <= '0;
            tmo_q     <= 1'b0;
`ifdef WB_BIST_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            len_q     <= len_d;
            seed_q    <= seed_d;
            inv_q     <= inv_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            dat_q     <= dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            first_q   <= first_d;
            tmo_q     <= tmo_d;
`ifdef WB_BIST_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    assign WBm_ADR_o       = adr_q;
    assign WBm_CYC_o       = cyc_q;
    assign WBm_STB_o       = cyc_q;
    assign WBm_WE_o        = we_q;
    assign WBm_BYTE_STB_o  = {4{cyc_q}};
    assign WBm_DAT_o       = dat_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign err_cnt_o       = err_q;
    assign first_err_adr_o = first_q;

endmodule

// File: tb/tb_wb_ram_bist_master.sv
// Scoreboard bench for wb_ram_bist_master: random runs against a fault-injecting RAM responder.
module tb_wb_ram_bist_master;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 32;
    localparam int unsigned NW = 2 ** AW;

    typedef struct {
        logic [AW-1:0] adr;
        logic [31:0]   dat;
    } wr_t;

    typedef struct {
        int err;
        int first;
        int pass;
        int lat;
        int t0;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [AW:0]   len_i = '0;
    logic [DW-1:0] seed_i = '0;
    logic          invert_i = 1'b0;
    logic [AW-1:0] adr;
    logic          cyc, stb, we;
    logic [3:0]    bstb;
    logic [DW-1:0] dat;
    logic [DW-1:0] rdat;
    logic          ack;
    logic          busy, done, pass;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_adr;

    wb_ram_bist_master dut (
        .WBs_CLK_i       (clk),
        .WBs_RST_i       (rst),
        .start_i         (start_i),
        .len_i           (len_i),
        .seed_i          (seed_i),
        .invert_i        (invert_i),
        .WBm_ADR_o       (adr),
        .WBm_CYC_o       (cyc),
        .WBm_STB_o       (stb),
        .WBm_WE_o        (we),
        .WBm_BYTE_STB_o  (bstb),
        .WBm_DAT_o       (dat),
        .WBm_DAT_i       (rdat),
        .WBm_ACK_i       (ack),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .err_cnt_o       (err_cnt),
        .first_err_adr_o (first_adr)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // RAM responder: registered ACK, random wait states, stuck-at-0 faults on readback.
    logic [31:0] mem [0:NW-1];
    logic [15:0] flt [0:NW-1];
    int          max_wait = 0;
    bit          hang = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack  <= 1'b0;
            rdat <= '0;
        end else if (cyc && stb && !ack && !hang && ($urandom_range(0, max_wait) == 0)) begin
            ack <= 1'b1;
            if (we) mem[adr] <= dat;
            else    rdat <= {16'($urandom), mem[adr][15:0] & ~flt[adr]};
        end else begin
            ack <= 1'b0;
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    int runs_done = 0;

    wr_t           wq[$];
    logic [AW-1:0] rq[$];
    res_t          resq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic note_fail(input string nm);
        n_chk++;
        $display("FAIL %s: unexpected event, required none (t=%0t)", nm, $time);
    endtask

    // Monitor: pops expectations whenever the bus completes an access or done_o pulses.
    wr_t           mon_w;
    logic [AW-1:0] mon_ra;
    res_t          mon_r;
    always @(negedge clk) begin
        if (!rst) begin
            if (cyc && stb && ack) begin
                if (we) begin
                    if (wq.size() == 0) note_fail("wr_unexpected");
                    else begin
                        mon_w = wq.pop_front();
                        chk("wr_adr", 32'(adr), 32'(mon_w.adr));
                        chk("wr_dat", dat, mon_w.dat);
                        chk("wr_bstb", 32'(bstb), 32'hF);
                    end
                end else begin
                    if (rq.size() == 0) note_fail("rd_unexpected");
                    else begin
                        mon_ra = rq.pop_front();
                        chk("rd_adr", 32'(adr), 32'(mon_ra));
                    end
                end
            end
            if (done) begin
                if (resq.size() == 0) note_fail("done_unexpected");
                else begin
                    mon_r = resq.pop_front();
                    chk("err_cnt", 32'(err_cnt), 32'(mon_r.err));
                    chk("first_err_adr", 32'(first_adr), 32'(mon_r.first));
                    chk("pass", 32'(pass), 32'(mon_r.pass));
                    chk("busy_at_done", 32'(busy), 32'd0);
                    if (mon_r.lat != 0) chk("latency", 32'(cyc_cnt - mon_r.t0), 32'(mon_r.lat));
                end
                runs_done++;
            end
        end
    end

    // Reference pattern computed in the 16-bit compare domain.
    function automatic logic [31:0] mpat(input int a, input logic [31:0] seed, input bit inv);
        logic [15:0] p;
        p = 16'(a) ^ seed[15:0];
        if (inv) p = ~p;
        return {16'h0, p};
    endfunction

    int last_t0 = 0;

    task automatic launch(input int len, input logic [31:0] seed, input bit inv, input int lat);
        int   e;
        int   fe;
        res_t r;
        logic [31:0] p;
        e  = 0;
        fe = 0;
        for (int a = 0; a < len; a++) begin
            p = mpat(a, seed, inv);
            if (!hang) begin
                wq.push_back('{adr: AW'(a), dat: p});
                rq.push_back(AW'(a));
                if ((p[15:0] & flt[a]) != 16'h0) begin
                    if (e == 0) fe = a;
                    e++;
                end
            end
        end
        r.err   = (e > 65535) ? 65535 : e;
        r.first = fe;
        r.pass  = (!hang && e == 0) ? 1 : 0;
        r.lat   = lat;
        @(negedge clk);
        r.t0    = cyc_cnt;
        last_t0 = cyc_cnt;
        resq.push_back(r);
        start_i  = 1'b1;
        len_i    = (AW + 1)'(len);
        seed_i   = seed;
        invert_i = inv;
    endtask

    task automatic flush_reset();
        rst = 1'b1;
        @(negedge clk);
        wq.delete();
        rq.delete();
        resq.delete();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int len, input bit poke, input bit coin, input int lat);
        int seen;
        int c;
        int budget;
        seen   = runs_done;
        c      = 0;
        budget = 10 * (len + 2) * (max_wait + 1) + 60;
        while (runs_done == seen && c < budget) begin
            @(negedge clk);
            c++;
            start_i  = 1'b0;
            len_i    = (AW + 1)'($urandom);
            seed_i   = $urandom;
            invert_i = 1'($urandom);
            if (poke && c == 10) start_i = 1'b1;
            if (coin && (cyc_cnt - last_t0) == lat) start_i = 1'b1;
        end
        if (runs_done == seen) begin
            note_fail("run_timeout");
            flush_reset();
        end
        @(negedge clk);
        start_i = 1'b0;
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        if (coin) begin
            chk("start_at_done_busy", 32'(busy), 32'd0);
            chk("start_at_done_cyc", 32'(cyc), 32'd0);
        end
    endtask

    task automatic run(input int len, input logic [31:0] seed, input bit inv);
        launch(len, seed, inv, (max_wait == 0) ? 6 * len + 2 : 0);
        wait_done(len, 1'b0, 1'b0, 0);
    endtask

    task automatic clear_faults();
        for (int a = 0; a < int'(NW); a++) flt[a] = 16'h0;
    endtask

    initial begin
        int  len;
        int  k;
        bit  found;
        clear_faults();
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_bstb", 32'(bstb), 32'd0);
        chk("rst_adr", 32'(adr), 32'd0);
        chk("rst_dat", dat, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_first", 32'(first_adr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(4, 32'h0, 1'b0);
        run(0, $urandom, 1'b0);

        flt[3] = 16'h0001;
        flt[5] = 16'h0001;
        run(8, 32'h0000_00A5, 1'b1);
        clear_faults();

        launch(20, $urandom, 1'($urandom), 6 * 20 + 2);
        wait_done(20, 1'b1, 1'b0, 0);

        launch(3, $urandom, 1'b0, 6 * 3 + 2);
        wait_done(3, 1'b0, 1'b1, 6 * 3 + 2);
        run(2, $urandom, 1'b1);

        // Reset pulse while reading address 2.
        launch(6, $urandom, 1'b0, 0);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (cyc && !we && adr == AW'(2)) found = 1'b1;
        end
        chk("rd_adr2_reached", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_cyc", 32'(cyc), 32'd0);
        chk("midrst_stb", 32'(stb), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        wq.delete();
        rq.delete();
        resq.delete();
        rst = 1'b0;
        @(negedge clk);
        run(5, $urandom, 1'b0);

        for (int r = 0; r < 8; r++) begin
            len      = $urandom_range(1, 40);
            max_wait = $urandom_range(0, 3);
            for (k = 0; k < 3; k++) flt[$urandom_range(0, len - 1)] = 16'($urandom);
            run(len, $urandom, 1'($urandom));
            clear_faults();
        end
        max_wait = 0;

        run(int'(NW), $urandom, 1'($urandom));

`ifdef WB_BIST_TIMEOUT_EN
        hang = 1'b1;
        launch(5, $urandom, 1'b0, 18);
        wait_done(5, 1'b0, 1'b0, 0);
        hang = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
